// File: rtl/dct_tile_assembler.sv
// dct_tile_assembler
//
// Front end for the combinational 8x8 2D DCT. Pixels arrive in raster order and
// are converted to 16-bit sign-magnitude words (bit15 sign, bits[14:4] integer
// magnitude, bits[3:0] zero fraction). 64 words are collected into an 8x8 tile.
// The whole tile is then presented in parallel. Two banks are used as a ping-pong
// pair, so one tile can fill while the other waits for the DCT.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   pix_data   unsigned 8-bit pixel
//   pix_valid  pix_data valid this cycle
//   pix_sof    first pixel of a tile (qualified by pix_valid)
//   pix_ready  a pixel can be accepted this cycle
//   blk_data   64 x 16-bit tile, word k = 8*row + col on bits [16k+15:16k]
//   blk_valid  a complete tile is on blk_data
//   blk_ready  downstream consumes the tile this cycle
//   sof_err    sticky: a tile was truncated by an early pix_sof
//
// Parameter:
//   LEVEL_SHIFT  1 = subtract 128 before conversion, 0 = unsigned pass-through

module dct_tile_assembler #(
    parameter bit LEVEL_SHIFT = 1'b0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [7:0]    pix_data,
    input  logic          pix_valid,
    input  logic          pix_sof,
    output logic          pix_ready,
    output logic [1023:0] blk_data,
    output logic          blk_valid,
    input  logic          blk_ready,
    output logic          sof_err
);

    typedef enum logic [1:0] {
        StEmpty,
        StFilling,
        StFull
    } bank_st_e;

    bank_st_e      bank_st_q [2];
    bank_st_e      bank_st_d [2];
    logic          wr_q, wr_d;
    logic          rd_q, rd_d;
    logic [5:0]    idx_q, idx_d;
    logic          sof_err_q, sof_err_d;

    // Tile storage carries no reset: contents only matter while a bank is FULL,
    // and bank state is what reset clears.
    logic [1023:0] bank_q [2];

    logic          wr_en;
    logic [5:0]    wr_addr;
    logic [15:0]   wr_word;
    logic          accept;
    logic          consume;

    logic          pix_sign;
    logic [7:0]    pix_mag;

    // Pixel to sign-magnitude word. Under level shift, pixel 128 maps to +0.
    // Negative values occur only for pixels below 128, so -0 cannot appear.
    always_comb begin
        pix_sign = 1'b0;
        pix_mag  = pix_data;
        if (LEVEL_SHIFT) begin
            if (pix_data[7]) begin
                pix_mag = {1'b0, pix_data[6:0]};
            end else begin
                pix_sign = 1'b1;
                pix_mag  = 8'd128 - pix_data;
            end
        end
        wr_word = {pix_sign, 3'b000, pix_mag, 4'b0000};
    end

    always_comb begin
        bank_st_d = bank_st_q;
        wr_d      = wr_q;
        rd_d      = rd_q;
        idx_d     = idx_q;
        sof_err_d = sof_err_q;
        wr_en     = 1'b0;
        wr_addr   = idx_q;

        pix_ready = (bank_st_q[wr_q] != StFull);
        blk_valid = (bank_st_q[rd_q] == StFull);
        accept    = pix_valid && pix_ready;
        consume   = blk_valid && blk_ready;

        // A consume always targets a FULL bank and an accept always targets a
        // non-FULL bank. The two updates below therefore never touch the same bank.
        if (consume) begin
            bank_st_d[rd_q] = StEmpty;
            rd_d            = ~rd_q;
        end

        if (accept) begin
            wr_en = 1'b1;
            if (pix_sof && (idx_q != 6'd0)) begin
                // Early start of frame: drop the partial tile and restart it with this sample.
                wr_addr            = 6'd0;
                idx_d              = 6'd1;
                sof_err_d          = 1'b1;
                bank_st_d[wr_q]    = StFilling;
            end else if (idx_q == 6'd63) begin
                bank_st_d[wr_q]    = StFull;
                wr_d               = ~wr_q;
                idx_d              = 6'd0;
            end else begin
                bank_st_d[wr_q]    = StFilling;
                idx_d              = idx_q + 6'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bank_st_q[0] <= StEmpty;
            bank_st_q[1] <= StEmpty;
            wr_q         <= 1'b0;
            rd_q         <= 1'b0;
            idx_q        <= 6'd0;
            sof_err_q    <= 1'b0;
        end else begin
            bank_st_q <= bank_st_d;
            wr_q      <= wr_d;
            rd_q      <= rd_d;
            idx_q     <= idx_d;
            sof_err_q <= sof_err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            bank_q[wr_q][{wr_addr, 4'b0000} +: 16] <= wr_word;
        end
    end

    // Gate the tile so the output reads zero whenever no tile is presented.
    assign blk_data = blk_valid ? bank_q[rd_q] : '0;
    assign sof_err  = sof_err_q;

endmodule
